// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
// 4-digit packed-BCD up/down counter with a time-multiplexed scan stage.
// The scan stage feeds one BCD nibble to a 7-segment decoder and drives the
// matching active-low common-anode enable.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, a scanned digit is dark (anode_out = 4'b1111) if it is 0
//   and every higher digit is also 0. Digit 0 is never blanked.
//   When undefined, every digit is lit during its slot.
//
// Handshake note: this block has no valid/ready interfaces. en/clr/up_dn are
// level inputs sampled on every rising clk edge, and all outputs are registered.

module bcd_scan_counter #(
    parameter int COUNT_DIV = 50_000_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        up_dn,
    output logic [15:0] count_out,
    output logic        carry_out,
    output logic [3:0]  digit_out,
    output logic [3:0]  anode_out
);

    // A divider of 1 still needs a 1-bit register; it simply never leaves 0.
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   count_q, count_d;
    logic          carry_q, carry_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    digit_q, digit_d;
    logic [3:0]    anode_q, anode_d;

    logic          tick;
    logic [15:0]   bcd_next;
    logic          wrap;
    logic          ripple;
    logic [3:0]    nib;
    logic          blank;

    assign tick = en && (presc_q == PRESC_MAX);

    // Ripple a +1 / -1 through the four BCD digits; a ripple out of digit 3 is the wrap.
    always_comb begin
        bcd_next = count_q;
        ripple   = 1'b1;
        nib      = 4'h0;
        for (int i = 0; i < 4; i++) begin
            nib = count_q[4*i +: 4];
            if (ripple) begin
                if (up_dn) begin
                    if (nib >= 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = nib + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_next[4*i +: 4] = nib - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        wrap = ripple;
    end

    // Prescaler and count next-state: clr beats a tick, en=0 freezes both.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        carry_d = 1'b0;
        if (clr) begin
            presc_d = '0;
            count_d = 16'h0000;
        end else if (tick) begin
            presc_d = '0;
            count_d = bcd_next;
            carry_d = wrap;
        end else if (en) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Scan slot timer and digit index; free-running, unaffected by en and clr.
    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Leading-zero test for the slot being scanned.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    blank = (count_q[15:4] == 12'h000);
            2'd2:    blank = (count_q[15:8] == 8'h00);
            2'd3:    blank = (count_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    // Select the scanned nibble and its anode enable for the output registers.
    always_comb begin
        case (idx_q)
            2'd0:    digit_d = count_q[3:0];
            2'd1:    digit_d = count_q[7:4];
            2'd2:    digit_d = count_q[11:8];
            default: digit_d = count_q[15:12];
        endcase
        anode_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    // Count-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= 16'h0000;
            carry_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    // Scan-side registers; outputs are registered so anode_out never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= '0;
            idx_q   <= 2'd0;
            digit_q <= 4'h0;
            anode_q <= 4'b1111;
        end else begin
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            anode_q <= anode_d;
        end
    end

    assign count_out = count_q;
    assign carry_out = carry_q;
    assign digit_out = digit_q;
    assign anode_out = anode_q;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- 4-digit BCD up/down counter with a time-multiplexed scan stage. Sits directly upstream of the 7-segment decoder.
- Each scan slot presents one BCD nibble on digit_out, which wires straight to the decoder's 4-bit input.
- Drives the matching active-low digit anode enable.
- Gives the board a free-running or gated decimal count on a 4-digit common-anode display.

Parameters:
- COUNT_DIV, 50_000_000: clk cycles per count tick (1 Hz at 50 MHz). Legal range ≥1; 1 means tick every enabled cycle.
- SCAN_DIV, 50_000: clk cycles per scan slot (1 kHz per digit at 50 MHz). Legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable. High: prescaler runs and ticks apply. Low: prescaler and count hold.
- clr  input  1  synchronous clear of count and prescaler.
- up_dn  input  1  count direction: 1 = up, 0 = down. Sampled on the tick cycle.
- count_out  output  16  packed BCD count, digit3 (thousands) in [15:12] down to digit0 (units) in [3:0].
- carry_out  output  1  one-cycle pulse on wrap: 9999→0000 going up, 0000→9999 going down.
- digit_out  output  4  BCD nibble of the currently scanned digit, to the decoder input.
- anode_out  output  4  active-low digit enables; bit i selects digit i.

Behaviour:
- Reset (async, rst=1):
  - count_out=16'h0000, carry_out=0, digit_out=4'h0, anode_out=4'b1111.
  - Prescaler=0, scan counter=0, scan index=0.
  - Reset asserted mid-count or mid-scan forces these values immediately, regardless of clk.
- Prescaler: counts 0..COUNT_DIV-1 while en=1. The cycle it equals COUNT_DIV-1 is a tick, and it returns to 0. en=0 holds its value.
- Tick, up (up_dn=1): digit0 increments.
  - A digit at 9 goes to 0 and carries into the next digit.
  - 9999→0000 and carry_out=1 for that one cycle.
- Tick, down (up_dn=0): digit0 decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - 0000→9999 and carry_out=1 for that one cycle.
- Count update latency: count_out is registered and changes on the clk edge that ends the tick cycle. carry_out is asserted in the same cycle as the wrapped count value.
- clr=1 has priority over a tick:
  - count=0000, prescaler=0, carry_out=0 next edge.
  - Applies even if en=0.
- carry_out is 0 in every cycle without a wrapping tick.
- Digits never leave 0..9; no BCD value 10..15 is ever produced.
- Scan: the scan counter runs 0..SCAN_DIV-1 continuously, independent of en and clr. On wrap, the scan index advances 0→1→2→3→0.
- Scan outputs are registered, one-cycle latency from index/count:
  - digit_out = count digit[index].
  - anode_out = all ones except bit[index]=0.
- First edge after reset release: anode_out=4'b1110, digit_out=digit0.
- Exactly one anode bit is low at any time after that first edge (without the optional feature).
- A count change mid-slot appears on digit_out one cycle later; there is no glitch on anode_out.

Optional Feature:
- LEADING_ZERO_BLANK_EN
- Defined:
  - When the scanned digit is 0 and all higher digits are 0, anode_out for that slot is 4'b1111 (digit dark).
  - digit0 is never blanked, so 0000 shows "0".
  - digit_out still carries the nibble.
- Undefined: every digit is always lit during its slot.

Test Plan (COUNT_DIV=1, SCAN_DIV=4 unless stated):
- Assert rst mid-count at count 0x0456 → count_out=0x0000, anode_out=4'b1111, carry_out=0 before the next clk edge; first edge after release gives anode_out=4'b1110.
- up_dn=1, en=1 from 0000 for 10 ticks → count_out=16'h0010; continue to 10000 total ticks → count_out=16'h0000, with carry_out high exactly one cycle at the wrap.
- up_dn=0, en=1 from 0000, one tick → count_out=16'h9999, carry_out pulses once; next tick → 16'h9998, carry_out=0.
- Count at 0x0123, en=1, clr and tick in the same cycle → count_out=0x0000, carry_out=0; with en=0 and clr=1 → count_out=0x0000.
- en=0, count held at 0x1234 → anode_out cycles 1110,1101,1011,0111, each held 4 cycles; digit_out 4,3,2,1 respectively; count_out unchanged.
- With LEADING_ZERO_BLANK_EN, count 0x0070 → anode low only in slots 0 and 1 (digit_out 0, 7); count 0x0000 → only slot 0 lit. Without the macro, all four slots are lit.
